// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus: result value, ROB address and the
// completed-op cell that execution units hand to the retire stage.
package cdb_arbiter_pkg;

    // System-wide number of execution units sharing the CDB write path.
    localparam int CDB_NUM_REQ = 4;

    localparam int XLEN   = 32;
    localparam int ROB_AW = 6;
    localparam int PRF_AW = 7;

    typedef logic [XLEN-1:0]   phy_rf_data_t;
    typedef logic [ROB_AW-1:0] rob_addr_t;
    typedef logic [PRF_AW-1:0] phy_reg_t;

    // optype[0] doubles as the valid bit on the retire-side interface.
    typedef struct packed {
        logic [3:0] optype;
        logic [7:0] opcode;
    } uop_t;

    typedef struct packed {
        uop_t      op;
        rob_addr_t rob_addr;
        phy_reg_t  dest;
    } res_st_cell_t;

    // Validity on the output comes only from the grant, never from the
    // producer's own optype bit.
    function automatic res_st_cell_t mark_valid(input res_st_cell_t c);
        res_st_cell_t r;
        r              = c;
        r.op.optype[0] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin grant: first requester at or after ptr in
// circular order, found by masking a doubled request vector so the wrap
// needs no special case.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;

    // Lowest set bit of the masked doubled vector; upper copy covers the wrap.
    always_comb begin
        logic          found;
        logic [IW-1:0] sel;
        req2    = {req, req};
        mask    = {(2*N){1'b1}} << ptr;
        masked  = req2 & mask;
        found   = 1'b0;
        sel     = '0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < 2*N; k++) begin
            if (masked[k] && !found) begin
                found = 1'b1;
                sel   = IW'((k >= N) ? (k - N) : k);
            end
        end
        if (en && found) begin
            gnt_any  = 1'b1;
            gnt_idx  = sel;
            gnt[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one completed result per cycle in
// round-robin order and registers it toward the retire stage.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic         [NUM_REQ-1:0]   req_valid,
    input  res_st_cell_t [NUM_REQ-1:0]   req_op,
    input  phy_rf_data_t [NUM_REQ-1:0]   req_value,
    output logic         [NUM_REQ-1:0]   req_ready,
    input  logic                         out_stall,
    output res_st_cell_t                 out_op,
    output phy_rf_data_t                 out_value,
    output logic [$clog2(NUM_REQ)-1:0]   out_src
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    res_st_cell_t  out_op_q, out_op_d;
    phy_rf_data_t  out_value_q, out_value_d;
    logic [IW-1:0] out_src_q, out_src_d;

    logic               arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;

    // No grant while stalled or held in reset, so producers keep their request.
    assign arb_en = !out_stall && rst_n;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign req_ready = gnt;

    // Next output is the granted result or a bubble; pointer moves past the winner.
    always_comb begin
        out_op_d    = '0;
        out_value_d = '0;
        out_src_d   = '0;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_any) begin
            out_op_d    = mark_valid(req_op[gnt_idx]);
            out_value_d = req_value[gnt_idx];
            out_src_d   = gnt_idx;
            rr_ptr_d    = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    // Pointer and output register; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_op_q    <= '0;
            out_value_q <= '0;
            out_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_op_q    <= out_op_d;
            out_value_q <= out_value_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_op    = out_op_q;
    assign out_value = out_value_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic, all
// checked against a queue-free behavioural model of round-robin service.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic         [N-1:0]     req_valid;
    res_st_cell_t [N-1:0]     req_op;
    phy_rf_data_t [N-1:0]     req_value;
    logic         [N-1:0]     req_ready;
    logic                     out_stall;
    res_st_cell_t             out_op;
    phy_rf_data_t             out_value;
    logic [$clog2(N)-1:0]     out_src;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_value (req_value),
        .req_ready (req_ready),
        .out_stall (out_stall),
        .out_op    (out_op),
        .out_value (out_value),
        .out_src   (out_src)
    );

    int errors = 0;
    int checks = 0;

    // Model: each producer's outstanding request and the service pointer.
    bit           pend[N];
    res_st_cell_t m_op[N];
    phy_rf_data_t m_val[N];
    int           m_ptr;
    int           wait_cnt[N];
    res_st_cell_t e_op;
    phy_rf_data_t e_val;
    int           e_src;
    logic [N-1:0] last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next served unit: first outstanding producer walking circularly from the pointer.
    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_op[i]    = m_op[i];
            req_value[i] = m_val[i];
        end
    endtask

    task automatic new_req(input int i);
        logic [$bits(res_st_cell_t)-1:0] r;
        r        = $bits(res_st_cell_t)'($urandom);
        pend[i]  = 1'b1;
        m_op[i]  = r;
        m_val[i] = $urandom;
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic step(input bit stall);
        int gi;
        out_stall = stall;
        drive();
        #1;
        last_ready = req_ready;
        gi = (stall || !rst_n) ? -1 : model_pick();
        chk("req_ready", req_ready, (gi >= 0) ? 64'(1) << gi : 64'(0));
        for (int i = 0; i < N; i++) begin
            if (pend[i] && !stall) begin
                wait_cnt[i] = req_ready[i] ? 0 : wait_cnt[i] + 1;
                chk("fairness", 64'(wait_cnt[i] < N), 64'(1));
            end
        end
        if (gi >= 0) begin
            e_op              = m_op[gi];
            e_op.op.optype[0] = 1'b1;
            e_val             = m_val[gi];
            e_src             = gi;
            pend[gi]          = 1'b0;
            m_ptr             = (gi + 1) % N;
        end else begin
            e_op  = '0;
            e_val = '0;
            e_src = 0;
        end
        @(negedge clk);
        chk("out_op", out_op, e_op);
        chk("out_value", out_value, e_val);
        chk("out_src", 64'(out_src), 64'(e_src));
    endtask

    // Reset asserted between edges; producers keep whatever they hold.
    task automatic async_reset();
        out_stall = 1'b0;
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_op", out_op, 64'(0));
        chk("rst_out_value", out_value, 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        m_ptr = 0;
        e_op  = '0;
        e_val = '0;
        e_src = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        @(negedge clk);
        chk("rst_hold_op", out_op, 64'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        out_stall = 1'b0;
        m_ptr     = 0;
        for (int i = 0; i < N; i++) begin
            pend[i]     = 1'b0;
            m_op[i]     = '0;
            m_val[i]    = '0;
            wait_cnt[i] = 0;
        end
        drive();
        repeat (3) @(negedge clk);
        chk("init_out_op", out_op, 64'(0));
        chk("init_out_value", out_value, 64'(0));
        chk("init_ready", 64'(req_ready), 64'(0));
        rst_n = 1'b1;

        // Single request on unit 2; producer's own optype[0] is clear.
        pend[2]             = 1'b1;
        m_op[2]             = '0;
        m_op[2].op.opcode   = 8'h11;
        m_op[2].rob_addr    = 6'd5;
        m_op[2].dest        = 7'd9;
        m_val[2]            = 32'hDEAD;
        step(1'b0);
        chk("t1_ready", 64'(last_ready), 64'(4'b0100));
        chk("t1_valid", 64'(out_op.op.optype[0]), 64'(1));
        chk("t1_rob", 64'(out_op.rob_addr), 64'(5));
        chk("t1_value", 64'(out_value), 64'(32'hDEAD));
        chk("t1_src", 64'(out_src), 64'(2));
        step(1'b0);
        chk("t1_bubble", 64'(out_op.op.optype[0]), 64'(0));

        // Pointer sits at 3: unit 3 wins, then unit 1 after the wrap.
        new_req(1);
        new_req(3);
        step(1'b0);
        chk("wrap_first", 64'(last_ready), 64'(4'b1000));
        step(1'b0);
        chk("wrap_second", 64'(last_ready), 64'(4'b0010));

        // Reset while a valid result is on the output.
        for (int i = 0; i < N; i++) new_req(i);
        step(1'b0);
        chk("mid_valid", 64'(out_op.op.optype[0]), 64'(1));
        async_reset();

        // All units continuously valid: strict rotation from index 0, no gaps.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) new_req(i);
            step(1'b0);
            chk("rot_ready", 64'(last_ready), 64'(1) << (c % 4));
            chk("rot_src", 64'(out_src), 64'(c % 4));
            chk("rot_valid", 64'(out_op.op.optype[0]), 64'(1));
        end

        // Two stalled cycles, then service resumes from the held pointer.
        for (int i = 0; i < N; i++) if (!pend[i]) new_req(i);
        repeat (2) begin
            step(1'b1);
            chk("stall_ready", 64'(last_ready), 64'(0));
            chk("stall_bubble", 64'(out_op.op.optype[0]), 64'(0));
        end
        step(1'b0);
        chk("stall_resume", 64'(last_ready), 64'(4'b0001));

        // Drain then idle.
        repeat (3) step(1'b0);
        repeat (4) begin
            step(1'b0);
            chk("idle_valid", 64'(out_op.op.optype[0]), 64'(0));
            chk("idle_value", 64'(out_value), 64'(0));
        end

        // Randomized traffic with stalls and occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(99) < 45)) new_req(i);
            end
            if ($urandom_range(99) < 2) async_reset();
            else step($urandom_range(99) < 15);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single result write path into the retire stage (its `value_in` / `op_in` pair) between `NUM_REQ` execution units. Each cycle it selects at most one valid completed result, acknowledges it to its producer, and presents it registered to the retire stage one cycle later. It sits between the execution units and `retire`, on the common data bus.

## Interface
- `NUM_REQ`, default 4: number of requesting execution units; legal range 2..16.
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: unit i holds a completed result.
- `req_op` in `NUM_REQ` x `res_st_cell_t`: completed op per unit; `rob_addr` and `dest` are meaningful.
- `req_value` in `NUM_REQ` x `phy_rf_data_t`: result value per unit.
- `req_ready` out `NUM_REQ`: one-hot (or zero) grant, combinational; transfer occurs when `req_valid[i] && req_ready[i]`.
- `out_stall` in 1: downstream requests a bubble this cycle.
- `out_op` out `res_st_cell_t`: op to retire stage; `out_op.op.optype[0]` is its valid bit.
- `out_value` out `phy_rf_data_t`: value to retire stage.
- `out_src` out `$clog2(NUM_REQ)`: index of the unit that produced `out_op`.

## Operation
- State: round-robin pointer `rr_ptr` (`$clog2(NUM_REQ)` bits), output register {`out_op`, `out_value`, `out_src`}.
- Grant search: lowest index i in circular order starting at `rr_ptr` with `req_valid[i]=1`; `req_ready[i]=1` for that i only.
- `out_stall=1` or `rst_n=0`: `req_ready` all 0, no grant.
- On grant to i: output register loads `req_op[i]`, `req_value[i]`, i, with `out_op.op.optype[0]` forced to 1; `rr_ptr` <= i+1, wrapping `NUM_REQ-1` -> 0.
- No grant (no valid request, or stall): output register loads a bubble: `out_op` all zeros (optype[0]=0), `out_value`=0, `out_src`=0; `rr_ptr` unchanged.
- A granted result appears on the output exactly once; the output is never held or repeated, because `retire` writes the ROB on every valid cycle.
- Requesters hold `req_valid`/`req_op`/`req_value` stable until granted; the arbiter does not buffer ungranted requests.
- Fairness: a continuously valid unit is granted within `NUM_REQ` non-stalled cycles.
- `req_op` with `optype[0]=0` while `req_valid=1` is still granted and forwarded, with optype[0] forced to 1 (valid comes only from `req_valid`).

## Timing
- Grant (`req_ready`) is combinational in the same cycle as `req_valid`; output latency is 1 cycle (registered).
- Throughput: 1 result/cycle when not stalled.
- Reset (asynchronous assert, any cycle including mid-transfer): `rr_ptr`=0, `out_op`=0, `out_value`=0, `out_src`=0, `req_ready`=0. An in-flight registered result is discarded; producers retain their request and re-arbitrate after release.
- First cycle after `rst_n` rises: arbitration is live and starts at index 0.
- `out_stall` affects the same-cycle grant and the next-cycle output (bubble); it does not affect the value already on the output this cycle.

## Structure
- `res_st_cell_t`, `phy_rf_data_t`, and `rob_addr_t` come from `qu_common`/`qu_uop`; add `CDB_NUM_REQ` (default 4) to `qu_common` as the system-wide port count.
- One sub-module: `rr_arbiter` (parameter N; inputs `req`, `ptr`, `en`; outputs one-hot `gnt`, `gnt_idx`, `gnt_any`), purely combinational, implemented with a double-width mask-and-priority scheme.
- Top level: `rr_ptr` register, output register, and muxes.

## Test plan
- Reset then single request: `req_valid=4'b0100`, `rob_addr`=5, value=0xDEAD -> `req_ready=4'b0100` the same cycle; next cycle `out_op` valid, `rob_addr`=5, `out_value`=0xDEAD, `out_src`=2; the cycle after is a bubble.
- All four valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; one output per cycle, no gaps.
- Pointer wrap: `rr_ptr`=3 with requests on units 1 and 3 -> unit 3 granted, then unit 1; `rr_ptr` becomes 0 and then 2.
- Stall: all units valid, `out_stall=1` for 2 cycles -> `req_ready`=0 in those cycles, next-cycle outputs are bubbles, `rr_ptr` is held, and arbitration resumes from the held pointer.
- Async reset mid-stream: assert `rst_n=0` between clock edges while the output is valid -> `out_op`=0 immediately; after release the first grant goes to the lowest valid index.
- Idle: `req_valid=0` -> `out_op.op.optype[0]`=0 every cycle and `out_value`=0.
